// File: rtl/uart_pkg.sv
// Definitions shared by the UART receiver and its downstream FIFO consumer.
// Holds the handshake state encoding and the default byte width.
package uart_pkg;

    localparam int UART_DATA_SIZE = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACK     = 2'd1,
        RELEASE = 2'd2
    } hs_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with an explicit occupancy counter.
// Carries no protocol knowledge; the parent decides when to push.
module uart_sync_fifo #(
    parameter  int DATA_SIZE = 8,
    parameter  int DEPTH     = 16,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 push,
    input  logic [DATA_SIZE-1:0] push_data,
    input  logic                 pop,
    output logic [DATA_SIZE-1:0] head,
    output logic                 valid,
    output logic [ADDR_W:0]      level
);

    localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(DEPTH);

    logic [DATA_SIZE-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]    wr_ptr;
    logic [ADDR_W-1:0]    rd_ptr;
    logic [ADDR_W:0]      count;
    logic                 do_push;
    logic                 do_pop;

    // A pop on an empty FIFO is ignored; a pop frees a slot for a same-cycle push.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL_LEVEL) || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (ADDR_W + 1)'(1);
                2'b01:   count <= count - (ADDR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Head reads as zero while empty so stale storage never leaks out.
    assign valid = (count != '0);
    assign head  = valid ? mem[rd_ptr] : '0;
    assign level = count;

endmodule

// File: rtl/uart_rx_fifo.sv
// Consumes the UART receiver's req/ack byte handshake and buffers bytes in a FIFO
// exposed through a valid/ready read port, with fill level and sticky overflow.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter  int DATA_SIZE    = UART_DATA_SIZE,
    parameter  int DEPTH        = 16,
    parameter  bit DROP_ON_FULL = 1'b1,
    localparam int ADDR_W       = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [DATA_SIZE-1:0] din,
    input  logic                 recv_req,
    output logic                 recv_ack,
    output logic [DATA_SIZE-1:0] rd_data,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [ADDR_W:0]      level,
    output logic                 overflow,
    input  logic                 ovf_clr
);

    localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(DEPTH);

    hs_state_t state;
    logic      space;
    logic      push;
    logic      drop;

    assign space = (level != FULL_LEVEL) || (rd_valid && rd_ready);
    assign push  = (state == IDLE) && recv_req && space;
    assign drop  = (state == IDLE) && recv_req && !space && DROP_ON_FULL;

    // RELEASE waits for req to fall so a held request is never captured twice.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            recv_ack <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (recv_req && (space || DROP_ON_FULL)) begin
                        recv_ack <= 1'b1;
                        state    <= ACK;
                    end
                end
                ACK: begin
                    recv_ack <= 1'b0;
                    state    <= RELEASE;
                end
                RELEASE: begin
                    if (!recv_req) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    recv_ack <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    // A drop in the same cycle as a clear must still leave the flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    uart_sync_fifo #(
        .DATA_SIZE (DATA_SIZE),
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (din),
        .pop       (rd_ready),
        .head      (rd_data),
        .valid     (rd_valid),
        .level     (level)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: instance a drops on full, instance b applies backpressure.
module tb_uart_rx_fifo;

    logic       clk;
    logic       reset_n;
    logic [7:0] a_din, b_din;
    logic       a_req, b_req;
    logic       a_ack, b_ack;
    logic [7:0] a_rd_data, b_rd_data;
    logic       a_rd_valid, b_rd_valid;
    logic       a_rd_ready, b_rd_ready;
    logic [4:0] a_level, b_level;
    logic       a_overflow, b_overflow;
    logic       a_ovf_clr, b_ovf_clr;

    int tests_run    = 0;
    int tests_failed = 0;

    uart_rx_fifo #(.DATA_SIZE(8), .DEPTH(16), .DROP_ON_FULL(1'b1)) dut_a (
        .clk(clk), .reset_n(reset_n), .din(a_din), .recv_req(a_req), .recv_ack(a_ack),
        .rd_data(a_rd_data), .rd_valid(a_rd_valid), .rd_ready(a_rd_ready),
        .level(a_level), .overflow(a_overflow), .ovf_clr(a_ovf_clr)
    );

    uart_rx_fifo #(.DATA_SIZE(8), .DEPTH(16), .DROP_ON_FULL(1'b0)) dut_b (
        .clk(clk), .reset_n(reset_n), .din(b_din), .recv_req(b_req), .recv_ack(b_ack),
        .rd_data(b_rd_data), .rd_valid(b_rd_valid), .rd_ready(b_rd_ready),
        .level(b_level), .overflow(b_overflow), .ovf_clr(b_ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Receiver model: hold req until ack is seen, drop it, then count ack pulses for two more cycles.
    task automatic send_byte(input bit sel, input logic [7:0] data, output int acks);
        bit seen;
        seen = 1'b0;
        acks = 0;
        if (sel) begin b_din = data; b_req = 1'b1; end
        else     begin a_din = data; a_req = 1'b1; end
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #1;
            if ((sel ? b_ack : a_ack) === 1'b1) begin
                seen = 1'b1;
                acks++;
            end
        end
        if (sel) b_req = 1'b0; else a_req = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            if ((sel ? b_ack : a_ack) === 1'b1) acks++;
        end
    endtask

    task automatic pop_one(input bit sel, output logic [7:0] data, output logic vld);
        data = sel ? b_rd_data : a_rd_data;
        vld  = sel ? b_rd_valid : a_rd_valid;
        if (sel) b_rd_ready = 1'b1; else a_rd_ready = 1'b1;
        @(posedge clk); #1;
        if (sel) b_rd_ready = 1'b0; else a_rd_ready = 1'b0;
    endtask

    task automatic test_reset();
        tests_run++;
        if ({a_ack, a_rd_valid, a_overflow, a_level, a_rd_data} !== 16'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_a: got ack=%b valid=%b ovf=%b level=%0d data=%h expected all zero",
                     a_ack, a_rd_valid, a_overflow, a_level, a_rd_data);
        end
        tests_run++;
        if ({b_ack, b_rd_valid, b_overflow, b_level, b_rd_data} !== 16'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_b: got ack=%b valid=%b ovf=%b level=%0d data=%h expected all zero",
                     b_ack, b_rd_valid, b_overflow, b_level, b_rd_data);
        end
    endtask

    task automatic test_single_byte();
        int acks;
        a_din = 8'hA5; a_req = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (a_ack !== 1'b1 || a_rd_valid !== 1'b1 || a_rd_data !== 8'hA5 || a_level !== 5'd1) begin
            tests_failed++;
            $display("[TB] FAIL single_capture: got ack=%b valid=%b data=%h level=%0d expected 1 1 a5 1",
                     a_ack, a_rd_valid, a_rd_data, a_level);
        end
        a_req = 1'b0;
        acks = 1;
        repeat (3) begin
            @(posedge clk); #1;
            if (a_ack === 1'b1) acks++;
        end
        tests_run++;
        if (acks != 1) begin
            tests_failed++;
            $display("[TB] FAIL single_ack_count: got %0d expected 1", acks);
        end
        a_rd_ready = 1'b1;
        @(posedge clk); #1;
        a_rd_ready = 1'b0;
        tests_run++;
        if (a_rd_valid !== 1'b0 || a_level !== 5'd0) begin
            tests_failed++;
            $display("[TB] FAIL single_pop: got valid=%b level=%0d expected 0 0", a_rd_valid, a_level);
        end
    endtask

    task automatic test_burst();
        int         acks;
        logic [7:0] d;
        logic       v;
        for (int i = 0; i < 16; i++) begin
            send_byte(1'b0, 8'(i), acks);
            tests_run++;
            if (acks != 1) begin
                tests_failed++;
                $display("[TB] FAIL burst_ack_%0d: got %0d acks expected 1", i, acks);
            end
        end
        tests_run++;
        if (a_level !== 5'd16 || a_overflow !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL burst_full: got level=%0d ovf=%b expected 16 0", a_level, a_overflow);
        end
        for (int i = 0; i < 16; i++) begin
            pop_one(1'b0, d, v);
            tests_run++;
            if (v !== 1'b1 || d !== 8'(i)) begin
                tests_failed++;
                $display("[TB] FAIL burst_drain_%0d: got valid=%b data=%h expected 1 %h", i, v, d, 8'(i));
            end
        end
        tests_run++;
        if (a_rd_valid !== 1'b0 || a_level !== 5'd0) begin
            tests_failed++;
            $display("[TB] FAIL burst_empty: got valid=%b level=%0d expected 0 0", a_rd_valid, a_level);
        end
        a_rd_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        a_rd_ready = 1'b0;
        tests_run++;
        if (a_rd_valid !== 1'b0 || a_level !== 5'd0 || a_rd_data !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL empty_pop: got valid=%b level=%0d data=%h expected 0 0 00",
                     a_rd_valid, a_level, a_rd_data);
        end
        send_byte(1'b0, 8'h3C, acks);
        tests_run++;
        if (a_rd_data !== 8'h3C || a_level !== 5'd1) begin
            tests_failed++;
            $display("[TB] FAIL after_empty_pop: got data=%h level=%0d expected 3c 1", a_rd_data, a_level);
        end
        pop_one(1'b0, d, v);
    endtask

    task automatic test_overflow();
        int acks;
        for (int i = 0; i < 16; i++) send_byte(1'b0, 8'(i), acks);
        send_byte(1'b0, 8'hEE, acks);
        tests_run++;
        if (acks != 1 || a_overflow !== 1'b1 || a_level !== 5'd16 || a_rd_data !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL drop_full: got acks=%0d ovf=%b level=%0d head=%h expected 1 1 16 00",
                     acks, a_overflow, a_level, a_rd_data);
        end
        // Drop and clear land on the same edge: the set must win.
        a_din = 8'hEF; a_req = 1'b1; a_ovf_clr = 1'b1;
        @(posedge clk); #1;
        a_ovf_clr = 1'b0; a_req = 1'b0;
        tests_run++;
        if (a_ack !== 1'b1 || a_overflow !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL ovf_set_priority: got ack=%b ovf=%b expected 1 1", a_ack, a_overflow);
        end
        repeat (2) @(posedge clk);
        #1;
        a_ovf_clr = 1'b1;
        @(posedge clk); #1;
        a_ovf_clr = 1'b0;
        tests_run++;
        if (a_overflow !== 1'b0 || a_level !== 5'd16) begin
            tests_failed++;
            $display("[TB] FAIL ovf_clear: got ovf=%b level=%0d expected 0 16", a_overflow, a_level);
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] d;
        logic       v;
        a_din = 8'h55; a_req = 1'b1; a_rd_ready = 1'b1;
        @(posedge clk); #1;
        a_rd_ready = 1'b0; a_req = 1'b0;
        tests_run++;
        if (a_ack !== 1'b1 || a_level !== 5'd16 || a_overflow !== 1'b0 || a_rd_data !== 8'h01) begin
            tests_failed++;
            $display("[TB] FAIL simul_push_pop: got ack=%b level=%0d ovf=%b head=%h expected 1 16 0 01",
                     a_ack, a_level, a_overflow, a_rd_data);
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 1; i < 17; i++) begin
            pop_one(1'b0, d, v);
            tests_run++;
            if (v !== 1'b1 || d !== ((i == 16) ? 8'h55 : 8'(i))) begin
                tests_failed++;
                $display("[TB] FAIL simul_drain_%0d: got valid=%b data=%h expected 1 %h",
                         i, v, d, (i == 16) ? 8'h55 : 8'(i));
            end
        end
        tests_run++;
        if (a_rd_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL simul_empty: got valid=%b expected 0", a_rd_valid);
        end
    endtask

    task automatic test_backpressure();
        int         acks;
        int         held_acks;
        logic [7:0] d;
        logic       v;
        for (int i = 0; i < 16; i++) send_byte(1'b1, 8'h10 + 8'(i), acks);
        b_din = 8'h77; b_req = 1'b1;
        held_acks = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (b_ack === 1'b1) held_acks++;
        end
        tests_run++;
        if (held_acks != 0 || b_level !== 5'd16 || b_overflow !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL bp_withhold: got acks=%0d level=%0d ovf=%b expected 0 16 0",
                     held_acks, b_level, b_overflow);
        end
        b_rd_ready = 1'b1;
        @(posedge clk); #1;
        b_rd_ready = 1'b0; b_req = 1'b0;
        tests_run++;
        if (b_ack !== 1'b1 || b_level !== 5'd16 || b_rd_data !== 8'h11) begin
            tests_failed++;
            $display("[TB] FAIL bp_release: got ack=%b level=%0d head=%h expected 1 16 11",
                     b_ack, b_level, b_rd_data);
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 1; i < 17; i++) begin
            pop_one(1'b1, d, v);
            tests_run++;
            if (v !== 1'b1 || d !== ((i == 16) ? 8'h77 : (8'h10 + 8'(i)))) begin
                tests_failed++;
                $display("[TB] FAIL bp_drain_%0d: got valid=%b data=%h expected 1 %h",
                         i, v, d, (i == 16) ? 8'h77 : (8'h10 + 8'(i)));
            end
        end
    endtask

    task automatic test_reset_mid_op();
        int acks;
        for (int i = 0; i < 5; i++) send_byte(1'b0, 8'hC0 + 8'(i), acks);
        a_din = 8'h9B; a_req = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (a_ack !== 1'b1 || a_level !== 5'd6) begin
            tests_failed++;
            $display("[TB] FAIL rst_pre: got ack=%b level=%0d expected 1 6", a_ack, a_level);
        end
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (a_ack !== 1'b0 || a_level !== 5'd0 || a_rd_valid !== 1'b0 || a_rd_data !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL rst_async: got ack=%b level=%0d valid=%b data=%h expected 0 0 0 00",
                     a_ack, a_level, a_rd_valid, a_rd_data);
        end
        a_din = 8'h6A;
        #2;
        reset_n = 1'b1;
        @(posedge clk); #1;
        a_req = 1'b0;
        tests_run++;
        if (a_ack !== 1'b1 || a_level !== 5'd1 || a_rd_data !== 8'h6A) begin
            tests_failed++;
            $display("[TB] FAIL rst_req_held: got ack=%b level=%0d data=%h expected 1 1 6a",
                     a_ack, a_level, a_rd_data);
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        a_din = '0; a_req = 1'b0; a_rd_ready = 1'b0; a_ovf_clr = 1'b0;
        b_din = '0; b_req = 1'b0; b_rd_ready = 1'b0; b_ovf_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        reset_n = 1'b1;
        @(posedge clk); #1;
        test_single_byte();
        test_burst();
        test_overflow();
        test_simultaneous();
        test_backpressure();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
